// File: rtl/counter_run_ctrl.sv
// Run sequencer for the up-counter datapath: performs cfg_reps count-to-limit runs separated by idle gaps.
// Optional macro CTRL_ERR_EN adds a sticky err flag for accepted illegal commands; without it err is tied to 0.
module counter_run_ctrl #(
    parameter int WIDTH      = 8,
    parameter int REP_W      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic [REP_W-1:0] run_idx,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, HOLD, GAP, DONE} state_t;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_PAUSE  = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] limit_q;
    logic [REP_W-1:0] reps_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             accept;
    logic             start_acc;
    logic             run_complete;
    logic             last_run;

    assign cmd_ready    = (state != ARM);
    assign accept       = cmd_valid & cmd_ready;
    assign start_acc    = accept && (cmd_op == OP_START) && (state == IDLE || state == DONE);
    assign run_complete = (state == RUN) && (cnt_val == limit_q);
    assign last_run     = (run_idx == reps_q - REP_W'(1));
    assign cnt_en       = (state == RUN) && (cnt_val != limit_q);

    // STOP has priority over run completion; PAUSE only diverts a run that is still counting.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_acc) state_nx = ARM;
            ARM:  state_nx = RUN;
            RUN: begin
                if (accept && cmd_op == OP_STOP)
                    state_nx = IDLE;
                else if (run_complete)
                    state_nx = last_run ? DONE : GAP;
                else if (accept && cmd_op == OP_PAUSE)
                    state_nx = HOLD;
            end
            HOLD: begin
                if (accept && cmd_op == OP_STOP)
                    state_nx = IDLE;
                else if (accept && cmd_op == OP_RESUME)
                    state_nx = RUN;
            end
            GAP: begin
                if (accept && cmd_op == OP_STOP)
                    state_nx = IDLE;
                else if (gap_cnt == GAP_LAST)
                    state_nx = ARM;
            end
            DONE:    state_nx = start_acc ? ARM : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            run_idx <= '0;
            limit_q <= '0;
            reps_q  <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nx;
            cnt_clr <= (state_nx == ARM);
            busy    <= (state_nx == ARM) || (state_nx == RUN) ||
                       (state_nx == HOLD) || (state_nx == GAP);
            done    <= (state_nx == DONE);
            gap_cnt <= (state == GAP && state_nx == GAP) ? gap_cnt + 1'b1 : '0;
            if (start_acc) begin
                run_idx <= '0;
                limit_q <= cfg_limit;
                reps_q  <= (cfg_reps == '0) ? REP_W'(1) : cfg_reps;
            end else if (state == RUN && state_nx == GAP) begin
                run_idx <= run_idx + 1'b1;
            end
        end
    end

`ifdef CTRL_ERR_EN
    logic illegal;

    // A PAUSE landing on the completion cycle is dropped as illegal; the run still completes.
    always_comb begin
        illegal = 1'b0;
        if (accept) begin
            case (state)
                IDLE, DONE: illegal = (cmd_op != OP_START);
                RUN:        illegal = (cmd_op == OP_START) || (cmd_op == OP_RESUME) ||
                                      (cmd_op == OP_PAUSE && run_complete);
                HOLD:       illegal = (cmd_op == OP_START) || (cmd_op == OP_PAUSE);
                GAP:        illegal = (cmd_op != OP_STOP);
                default:    illegal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (start_acc)
            err <= 1'b0;
        else if (illegal)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl; models the 8-bit up-counter datapath and checks each scenario cycle by cycle.
module tb_counter_run_ctrl;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_PAUSE  = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;
`ifdef CTRL_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = 2'b00;
    logic [7:0] cfg_limit = 8'd0;
    logic [3:0] cfg_reps  = 4'd0;
    logic [7:0] cnt_val   = 8'd0;
    logic       cmd_ready;
    logic       cnt_clr;
    logic       cnt_en;
    logic       busy;
    logic [3:0] run_idx;
    logic       done;
    logic       err;
    logic [4:0] flags;

    int vectors     = 0;
    int miscompares = 0;

    counter_run_ctrl #(.WIDTH(8), .REP_W(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cfg_limit(cfg_limit), .cfg_reps(cfg_reps), .cnt_val(cnt_val), .cnt_clr(cnt_clr),
        .cnt_en(cnt_en), .busy(busy), .run_idx(run_idx), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Counter datapath: clear wins over enable.
    always @(posedge clk) begin
        if (cnt_clr)
            cnt_val <= 8'd0;
        else if (cnt_en)
            cnt_val <= cnt_val + 8'd1;
    end

    assign flags = {cmd_ready, cnt_clr, cnt_en, busy, done};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] lim, input logic [3:0] reps);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cfg_limit = lim;
        cfg_reps  = reps;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        vectors++;
        if ({err, flags, run_idx} !== {1'b0, 5'b10000, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got %h, expected %h", {err, flags, run_idx}, {1'b0, 5'b10000, 4'd0});
        end
        tick;
        rst = 1'b0;
        tick;
        vectors++;
        if ({err, flags, run_idx} !== {1'b0, 5'b10000, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got %h, expected %h", {err, flags, run_idx}, {1'b0, 5'b10000, 4'd0});
        end
    endtask

    task automatic test_single_run;
        issue(OP_START, 8'd5, 4'd1);
        tick;
        cmd_valid = 1'b0;
        vectors++;
        if (flags !== 5'b01010) begin
            miscompares++;
            $display("[TB] FAIL single_arm: got %b, expected %b", flags, 5'b01010);
        end
        for (int i = 0; i < 5; i++) begin
            tick;
            vectors++;
            if ({flags, cnt_val} !== {5'b10110, 8'(i)}) begin
                miscompares++;
                $display("[TB] FAIL single_count%0d: got %h, expected %h", i, {flags, cnt_val}, {5'b10110, 8'(i)});
            end
        end
        tick;
        vectors++;
        if ({flags, cnt_val} !== {5'b10010, 8'd5}) begin
            miscompares++;
            $display("[TB] FAIL single_limit: got %h, expected %h", {flags, cnt_val}, {5'b10010, 8'd5});
        end
        tick;
        vectors++;
        if ({flags, run_idx} !== {5'b10001, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL single_done: got %h, expected %h", {flags, run_idx}, {5'b10001, 4'd0});
        end
        tick;
        vectors++;
        if (flags !== 5'b10000) begin
            miscompares++;
            $display("[TB] FAIL single_idle: got %b, expected %b", flags, 5'b10000);
        end
    endtask

    task automatic test_multi_run;
        issue(OP_START, 8'd3, 4'd3);
        tick;
        cmd_valid = 1'b0;
        vectors++;
        if ({flags, run_idx} !== {5'b01010, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL multi_arm0: got %h, expected %h", {flags, run_idx}, {5'b01010, 4'd0});
        end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                tick;
                vectors++;
                if ({flags, run_idx, cnt_val} !== {5'b10110, 4'(r), 8'(i)}) begin
                    miscompares++;
                    $display("[TB] FAIL multi_run%0d_cnt%0d: got %h, expected %h", r, i,
                             {flags, run_idx, cnt_val}, {5'b10110, 4'(r), 8'(i)});
                end
            end
            tick;
            vectors++;
            if ({flags, run_idx, cnt_val} !== {5'b10010, 4'(r), 8'd3}) begin
                miscompares++;
                $display("[TB] FAIL multi_run%0d_limit: got %h, expected %h", r,
                         {flags, run_idx, cnt_val}, {5'b10010, 4'(r), 8'd3});
            end
            if (r < 2) begin
                for (int g = 0; g < 2; g++) begin
                    tick;
                    vectors++;
                    if ({flags, run_idx} !== {5'b10010, 4'(r + 1)}) begin
                        miscompares++;
                        $display("[TB] FAIL multi_gap%0d_%0d: got %h, expected %h", r, g,
                                 {flags, run_idx}, {5'b10010, 4'(r + 1)});
                    end
                end
                tick;
                vectors++;
                if ({flags, run_idx} !== {5'b01010, 4'(r + 1)}) begin
                    miscompares++;
                    $display("[TB] FAIL multi_arm%0d: got %h, expected %h", r + 1,
                             {flags, run_idx}, {5'b01010, 4'(r + 1)});
                end
            end else begin
                tick;
                vectors++;
                if ({flags, run_idx} !== {5'b10001, 4'd2}) begin
                    miscompares++;
                    $display("[TB] FAIL multi_done: got %h, expected %h", {flags, run_idx}, {5'b10001, 4'd2});
                end
            end
        end
        tick;
        vectors++;
        if (flags !== 5'b10000) begin
            miscompares++;
            $display("[TB] FAIL multi_idle: got %b, expected %b", flags, 5'b10000);
        end
    endtask

    task automatic test_pause;
        issue(OP_START, 8'd10, 4'd1);
        tick;
        cmd_valid = 1'b0;
        repeat (4) tick;
        vectors++;
        if ({flags, cnt_val} !== {5'b10110, 8'd3}) begin
            miscompares++;
            $display("[TB] FAIL pause_pre: got %h, expected %h", {flags, cnt_val}, {5'b10110, 8'd3});
        end
        cmd_valid = 1'b1;
        cmd_op    = OP_PAUSE;
        tick;
        cmd_valid = 1'b0;
        for (int h = 0; h < 6; h++) begin
            vectors++;
            if ({flags, cnt_val} !== {5'b10010, 8'd4}) begin
                miscompares++;
                $display("[TB] FAIL pause_hold%0d: got %h, expected %h", h, {flags, cnt_val}, {5'b10010, 8'd4});
            end
            if (h < 5) tick;
        end
        cmd_valid = 1'b1;
        cmd_op    = OP_RESUME;
        tick;
        cmd_valid = 1'b0;
        for (int v = 4; v < 10; v++) begin
            vectors++;
            if ({flags, cnt_val} !== {5'b10110, 8'(v)}) begin
                miscompares++;
                $display("[TB] FAIL pause_resume%0d: got %h, expected %h", v, {flags, cnt_val}, {5'b10110, 8'(v)});
            end
            tick;
        end
        vectors++;
        if ({flags, cnt_val} !== {5'b10010, 8'd10}) begin
            miscompares++;
            $display("[TB] FAIL pause_limit: got %h, expected %h", {flags, cnt_val}, {5'b10010, 8'd10});
        end
        tick;
        vectors++;
        if (flags !== 5'b10001) begin
            miscompares++;
            $display("[TB] FAIL pause_done: got %b, expected %b", flags, 5'b10001);
        end
        tick;
    endtask

    task automatic test_stop;
        issue(OP_START, 8'd7, 4'd2);
        tick;
        cmd_valid = 1'b0;
        repeat (19) tick;
        vectors++;
        if ({flags, run_idx, cnt_val} !== {5'b10010, 4'd1, 8'd7}) begin
            miscompares++;
            $display("[TB] FAIL stop_pre: got %h, expected %h", {flags, run_idx, cnt_val}, {5'b10010, 4'd1, 8'd7});
        end
        cmd_valid = 1'b1;
        cmd_op    = OP_STOP;
        tick;
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({flags, run_idx, cnt_val} !== {5'b10000, 4'd1, 8'd7}) begin
                miscompares++;
                $display("[TB] FAIL stop_idle%0d: got %h, expected %h", k,
                         {flags, run_idx, cnt_val}, {5'b10000, 4'd1, 8'd7});
            end
            tick;
        end
    endtask

    task automatic test_zero_limit;
        logic [8:0] exp_seq [7];
        exp_seq = '{{5'b01010, 4'd0}, {5'b10010, 4'd0}, {5'b10010, 4'd1}, {5'b10010, 4'd1},
                    {5'b01010, 4'd1}, {5'b10010, 4'd1}, {5'b10001, 4'd1}};
        issue(OP_START, 8'd0, 4'd2);
        for (int s = 0; s < 7; s++) begin
            tick;
            cmd_valid = 1'b0;
            vectors++;
            if ({flags, run_idx} !== exp_seq[s]) begin
                miscompares++;
                $display("[TB] FAIL zero_step%0d: got %h, expected %h", s, {flags, run_idx}, exp_seq[s]);
            end
        end
        // START presented during the done pulse, with reps=0 meaning a single run.
        issue(OP_START, 8'd2, 4'd0);
        tick;
        cmd_valid = 1'b0;
        vectors++;
        if ({flags, run_idx} !== {5'b01010, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL reps0_arm: got %h, expected %h", {flags, run_idx}, {5'b01010, 4'd0});
        end
        repeat (3) tick;
        vectors++;
        if ({flags, cnt_val} !== {5'b10010, 8'd2}) begin
            miscompares++;
            $display("[TB] FAIL reps0_limit: got %h, expected %h", {flags, cnt_val}, {5'b10010, 8'd2});
        end
        tick;
        vectors++;
        if ({flags, run_idx} !== {5'b10001, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL reps0_done: got %h, expected %h", {flags, run_idx}, {5'b10001, 4'd0});
        end
        tick;
    endtask

    task automatic test_err;
        cmd_valid = 1'b1;
        cmd_op    = OP_RESUME;
        tick;
        cmd_valid = 1'b0;
        vectors++;
        if ({err, flags} !== {ERR_ON, 5'b10000}) begin
            miscompares++;
            $display("[TB] FAIL err_set: got %h, expected %h", {err, flags}, {ERR_ON, 5'b10000});
        end
        tick;
        vectors++;
        if ({err, flags} !== {ERR_ON, 5'b10000}) begin
            miscompares++;
            $display("[TB] FAIL err_sticky: got %h, expected %h", {err, flags}, {ERR_ON, 5'b10000});
        end
        issue(OP_START, 8'd1, 4'd1);
        tick;
        cmd_valid = 1'b0;
        vectors++;
        if ({err, flags} !== {1'b0, 5'b01010}) begin
            miscompares++;
            $display("[TB] FAIL err_clear: got %h, expected %h", {err, flags}, {1'b0, 5'b01010});
        end
        repeat (3) tick;
        vectors++;
        if ({err, flags} !== {1'b0, 5'b10001}) begin
            miscompares++;
            $display("[TB] FAIL err_done: got %h, expected %h", {err, flags}, {1'b0, 5'b10001});
        end
        tick;
    endtask

    task automatic test_async_reset;
        issue(OP_START, 8'd10, 4'd1);
        tick;
        cmd_valid = 1'b0;
        repeat (3) tick;
        issue(OP_START, 8'd4, 4'd3);
        tick;
        cmd_valid = 1'b0;
        vectors++;
        if ({err, flags, cnt_val} !== {ERR_ON, 5'b10110, 8'd3}) begin
            miscompares++;
            $display("[TB] FAIL busy_start: got %h, expected %h", {err, flags, cnt_val}, {ERR_ON, 5'b10110, 8'd3});
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({err, flags, run_idx} !== {1'b0, 5'b10000, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h, expected %h", {err, flags, run_idx}, {1'b0, 5'b10000, 4'd0});
        end
        tick;
        rst = 1'b0;
        tick;
        vectors++;
        if (flags !== 5'b10000) begin
            miscompares++;
            $display("[TB] FAIL post_reset: got %b, expected %b", flags, 5'b10000);
        end
    endtask

    initial begin
        test_reset;
        test_single_run;
        test_multi_run;
        test_pause;
        test_stop;
        test_zero_limit;
        test_err;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

endmodule
